// File: rtl/gesture_box_overlay.sv
// Gesture bounding-box overlay for the RGB565 LCD stream.
// Box coordinates are shadowed at each vsync rise and held for the whole frame, so the
// rectangle never tears. Data and syncs leave exactly one clock after they arrive.
// Build option: define CROSSHAIR_EN to also draw a 1-pixel crosshair through the box centre
// in ~BOX_COLOR. The default build draws the border only.
module gesture_box_overlay #(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter int unsigned LINE_W    = 2,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [15:0] per_img_data,
  input  logic        box_en,
  input  logic [9:0]  box_x_min,
  input  logic [9:0]  box_x_max,
  input  logic [9:0]  box_y_min,
  input  logic [9:0]  box_y_max,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [15:0] post_img_data,
  output logic        box_active
);

  logic        vsync_d;
  logic        vs_rise;
  logic [9:0]  sh_x_min, sh_x_max, sh_y_min, sh_y_max;
  logic        sh_valid;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;

  assign vs_rise    = per_frame_vsync & ~vsync_d;
  assign box_active = sh_valid;

  // Vsync history and per-frame shadow of the detector box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d  <= 1'b0;
      sh_x_min <= '0;
      sh_x_max <= '0;
      sh_y_min <= '0;
      sh_y_max <= '0;
      sh_valid <= 1'b0;
    end else begin
      vsync_d <= per_frame_vsync;
      if (vs_rise) begin
        sh_x_min <= box_x_min;
        sh_x_max <= box_x_max;
        sh_y_min <= box_y_min;
        sh_y_max <= box_y_max;
        sh_valid <= box_en & (box_x_min <= box_x_max) & (box_y_min <= box_y_max);
      end
    end
  end

  // Pixel position counters; held at the origin during vertical blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (per_frame_vsync) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (per_frame_clken) begin
      if (x_cnt == 11'(IMG_W - 1)) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == 10'(IMG_H - 1)) ? '0 : y_cnt + 10'd1;
      end else begin
        x_cnt <= x_cnt + 11'd1;
      end
    end
  end

  // Hit test in 11-bit unsigned; edges are compared by adding LINE_W, never subtracting.
  logic [10:0] xs, ys, lw, xmin, xmax, ymin, ymax;
  logic        in_x, in_y, edge_l, edge_r, edge_t, edge_b, hit;

  always_comb begin
    xs     = x_cnt;
    ys     = {1'b0, y_cnt};
    lw     = 11'(LINE_W);
    xmin   = {1'b0, sh_x_min};
    xmax   = {1'b0, sh_x_max};
    ymin   = {1'b0, sh_y_min};
    ymax   = {1'b0, sh_y_max};
    in_x   = (xs >= xmin) && (xs <= xmax);
    in_y   = (ys >= ymin) && (ys <= ymax);
    edge_l = xs < (xmin + lw);
    edge_r = (xs + lw) > xmax;
    edge_t = ys < (ymin + lw);
    edge_b = (ys + lw) > ymax;
    hit    = sh_valid & in_x & in_y & (edge_l | edge_r | edge_t | edge_b);
  end

  logic [15:0] pix_next;

`ifdef CROSSHAIR_EN
  logic       vs_rise_d;
  logic [9:0] cx, cy;
  logic       cross_hit;

  // Centre is taken one clock after the shadow latch, from the freshly shadowed box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_rise_d <= 1'b0;
      cx        <= '0;
      cy        <= '0;
    end else begin
      vs_rise_d <= vs_rise;
      if (vs_rise_d) begin
        cx <= 10'(({1'b0, sh_x_min} + {1'b0, sh_x_max}) >> 1);
        cy <= 10'(({1'b0, sh_y_min} + {1'b0, sh_y_max}) >> 1);
      end
    end
  end

  // Crosshair wins over the border colour.
  always_comb begin
    cross_hit = sh_valid & (((xs == {1'b0, cx}) & in_y) | ((ys == {1'b0, cy}) & in_x));
    pix_next  = per_img_data;
    if (per_frame_clken & cross_hit) begin
      pix_next = ~BOX_COLOR;
    end else if (per_frame_clken & hit) begin
      pix_next = BOX_COLOR;
    end
  end
`else
  // Border only.
  always_comb begin
    pix_next = per_img_data;
    if (per_frame_clken & hit) begin
      pix_next = BOX_COLOR;
    end
  end
`endif

  // Single output stage: data and syncs share the same one-clock latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_data    <= '0;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      post_img_data    <= pix_next;
    end
  end

endmodule
